responde_medida_dht11: RTL and testbench



---
 rtl/dht11_pkg.sv | 29 ++
 rtl/tx_serial_8O1.sv | 67 ++++++
 rtl/responde_medida_dht11.sv | 114 +++++++++++
 tb/tb_responde_medida_dht11.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared encodings and constants for the DHT11 measurement responder
package dht11_pkg;

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    CAPTURA     = 4'd1,
    INICIA_BYTE = 4'd2,
    TRANSMITE   = 4'd3,
    INTERVALO   = 4'd4,
    PROXIMO     = 4'd5,
    FIM         = 4'd6
  } estado_t;

  localparam int CLK_P_BIT_DEF = 5208;
  localparam int FRAME_BITS    = 11;
  localparam int IDX_W         = 2;

  // Index 0 is the humidity high byte; temperature low byte goes last.
  function automatic logic [7:0] seleciona_byte(input logic [31:0] palavra,
                                                input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    seleciona_byte = palavra[31:24];
      2'd1:    seleciona_byte = palavra[23:16];
      2'd2:    seleciona_byte = palavra[15:8];
      default: seleciona_byte = palavra[7:0];
    endcase
  endfunction

endpackage

// File: rtl/tx_serial_8O1.sv
// rtl/tx_serial_8O1.sv - single-byte UART transmitter, 8 data bits, odd parity, 1 stop bit
module tx_serial_8O1
  import dht11_pkg::*;
#(
  parameter int CLK_P_BIT = CLK_P_BIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados,
  output logic       saida_serial,
  output logic       fim
);

  localparam int CW = $clog2(CLK_P_BIT + 1);

  logic [10:0]   shift_q, shift_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    bit_q, bit_d;
  logic          ativo_q, ativo_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '1;
      cyc_q   <= '0;
      bit_q   <= '0;
      ativo_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      ativo_q <= ativo_d;
    end
  end

  always_comb begin
    shift_d = shift_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    ativo_d = ativo_q;
    fim     = 1'b0;
    if (partida) begin
      shift_d = {1'b1, ~^dados, dados, 1'b0};
      cyc_d   = '0;
      bit_d   = '0;
      ativo_d = 1'b1;
    end else if (ativo_q) begin
      if (cyc_q == CW'(CLK_P_BIT - 1)) begin
        cyc_d = '0;
        if (bit_q == 4'(FRAME_BITS - 1)) begin
          // Stop bit stays on the line after the frame, so no final shift.
          ativo_d = 1'b0;
          bit_d   = '0;
          fim     = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[10:1]};
        end
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end
  end

  assign saida_serial = shift_q[0];

endmodule

// File: rtl/responde_medida_dht11.sv
// rtl/responde_medida_dht11.sv - far-end responder sending latched humidity/temperature as four UART frames
module responde_medida_dht11
  import dht11_pkg::*;
#(
  parameter int CLK_P_BIT = CLK_P_BIT_DEF,
  parameter int GAP_BITS  = 2,
  parameter int N_BYTES   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic [15:0] umidade_in,
  input  logic [15:0] temperatura_in,
  output logic        tx_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int GAP_CYC = GAP_BITS * CLK_P_BIT;
  localparam int GW      = $clog2(GAP_CYC + 1);

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             borda, partida, fim_byte;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      idx_q    <= '0;
      shadow_q <= '0;
      gap_q    <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      gap_q    <= gap_d;
      sync1_q  <= medir;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

  // Edge tracking runs in every state, so a level held through FIM never retriggers.
  assign borda = sync2_q & ~prev_q;

  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    gap_d    = gap_q;
    partida  = 1'b0;
    ocupado  = 1'b1;
    pronto   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        ocupado = 1'b0;
        if (borda) estado_d = CAPTURA;
      end
      CAPTURA: begin
        shadow_d = {umidade_in, temperatura_in};
        idx_d    = '0;
        estado_d = INICIA_BYTE;
      end
      INICIA_BYTE: begin
        partida  = 1'b1;
        estado_d = TRANSMITE;
      end
      TRANSMITE: begin
        if (fim_byte) begin
          gap_d    = '0;
          estado_d = INTERVALO;
        end
      end
      INTERVALO: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          estado_d = (idx_q == IDX_W'(N_BYTES - 1)) ? FIM : PROXIMO;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      PROXIMO: begin
        idx_d    = idx_q + IDX_W'(1);
        estado_d = INICIA_BYTE;
      end
      FIM: begin
        pronto   = 1'b1;
        ocupado  = 1'b0;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  tx_serial_8O1 #(
    .CLK_P_BIT(CLK_P_BIT)
  ) u_tx (
    .clock       (clock),
    .reset       (reset),
    .partida     (partida),
    .dados       (seleciona_byte(shadow_q, idx_q)),
    .saida_serial(tx_serial),
    .fim         (fim_byte)
  );

  assign db_estado = estado_q;

endmodule

// File: tb/tb_responde_medida_dht11.sv
// tb/tb_responde_medida_dht11.sv - scoreboard bench for the DHT11 responder
module tb_responde_medida_dht11;

  localparam int P   = 16;
  localparam int GAP = 2;
  localparam int NB  = 4;
  localparam int BYTE_PERIOD = (11 + GAP) * P + 2;
  localparam int PRONTO_OFS  = NB * (11 + GAP) * P + 2 * (NB - 1);

  typedef struct {
    logic [7:0] b;
    logic       par;
    int         start;
  } frame_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        medir = 1'b0;
  logic [15:0] umidade_in = 16'hBADE;
  logic [15:0] temperatura_in = 16'h1234;
  logic        tx_serial, ocupado, pronto;
  logic [3:0]  db_estado;

  responde_medida_dht11 #(.CLK_P_BIT(P), .GAP_BITS(GAP)) dut (
    .clock         (clock),
    .reset         (reset),
    .medir         (medir),
    .umidade_in    (umidade_in),
    .temperatura_in(temperatura_in),
    .tx_serial     (tx_serial),
    .ocupado       (ocupado),
    .pronto        (pronto),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  frame_t exp_q[$];
  int     pronto_q[$];
  int     n_vec = 0;
  int     n_bad = 0;
  int     pronto_seen = 0;
  logic   line_low_seen = 1'b0;

  logic [7:0] tab_b[4]   = '{8'hBA, 8'hDE, 8'h12, 8'h34};
  logic       tab_par[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
  endtask

  // Monitor: deserialises frames on tx_serial and checks them against the scoreboard.
  logic        rx_active = 1'b0;
  int          rx_start, t, bi, pos;
  logic [10:0] rx_bits;
  logic        width_ok;
  frame_t      e;

  always @(negedge clock) begin
    if (reset) begin
      rx_active = 1'b0;
    end else begin
      if (tx_serial === 1'b0) line_low_seen = 1'b1;
      if (!rx_active) begin
        if (tx_serial === 1'b0) begin
          rx_active = 1'b1;
          rx_start  = cyc;
          width_ok  = 1'b1;
          rx_bits   = '1;
          rx_bits[0] = tx_serial;
        end
      end else begin
        t   = cyc - rx_start;
        bi  = t / P;
        pos = t % P;
        if (pos == 0) rx_bits[bi] = tx_serial;
        else if (tx_serial !== rx_bits[bi]) width_ok = 1'b0;
        if (t == 11 * P - 1) begin
          rx_active = 1'b0;
          if (exp_q.size() == 0) begin
            fail_now("frame_unexpected");
          end else begin
            e = exp_q.pop_front();
            chk("frame_start_bit", 32'(rx_bits[0]), 32'd0);
            chk("frame_data", 32'(rx_bits[8:1]), 32'(e.b));
            chk("frame_parity", 32'(rx_bits[9]), 32'(e.par));
            chk("frame_stop_bit", 32'(rx_bits[10]), 32'd1);
            chk("bit_width", 32'(width_ok), 32'd1);
            chk("frame_start_cycle", rx_start, e.start);
            chk("ocupado_in_frame", 32'(ocupado), 32'd1);
          end
        end
      end
      if (pronto === 1'b1) begin
        pronto_seen++;
        if (pronto_q.size() == 0) begin
          fail_now("pronto_unexpected");
        end else begin
          chk("pronto_cycle", cyc, pronto_q.pop_front());
          chk("ocupado_at_pronto", 32'(ocupado), 32'd0);
        end
      end
    end
  end

  // Request with a one-cycle medir pulse; medir is sampled at the following posedge (edge N).
  task automatic request();
    int n0;
    frame_t f;
    @(negedge clock);
    medir = 1'b1;
    n0 = cyc + 1;
    for (int k = 0; k < NB; k++) begin
      f.b = tab_b[k];
      f.par = tab_par[k];
      f.start = n0 + 4 + k * BYTE_PERIOD;
      exp_q.push_back(f);
    end
    pronto_q.push_back(n0 + 4 + PRONTO_OFS);
    @(negedge clock);
    medir = 1'b0;
  endtask

  task automatic wait_pronto(input int budget);
    int target;
    target = pronto_seen + 1;
    for (int i = 0; i < budget && pronto_seen < target; i++) @(negedge clock);
    chk("pronto_within_budget", 32'(pronto_seen >= target), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    // 1: reset state and quiet line
    repeat (2) @(negedge clock);
    chk("reset_tx", 32'(tx_serial), 32'd1);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_pronto", 32'(pronto), 32'd0);
    chk("reset_estado", 32'(db_estado), 32'd0);
    reset = 1'b0;
    line_low_seen = 1'b0;
    idle(300);
    chk("idle_after_reset", 32'(line_low_seen), 32'd0);
    chk("idle_estado", 32'(db_estado), 32'd0);

    // 2: basic response
    request();
    wait_pronto(2000);
    idle(20);

    // 3: retrigger during byte 1 ignored, level held through FIM does not restart
    request();
    idle(BYTE_PERIOD + 5 * P);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    idle(BYTE_PERIOD + 12 * P);
    medir = 1'b1;
    wait_pronto(2000);
    line_low_seen = 1'b0;
    idle(500);
    chk("no_retrigger_after_fim", 32'(line_low_seen), 32'd0);
    chk("idle_ocupado_held", 32'(ocupado), 32'd0);
    medir = 1'b0;
    idle(20);

    // 4: inputs change right after capture
    request();
    idle(3);
    umidade_in = 16'h0000;
    temperatura_in = 16'hFFFF;
    wait_pronto(2000);
    umidade_in = 16'hBADE;
    temperatura_in = 16'h1234;
    idle(20);

    // 5: reset during byte 2 data bits, then a fresh full response
    request();
    idle(2 * BYTE_PERIOD + 4 + 4 * P + 3);
    chk("mid_byte2_line_low_or_high_is_data", 32'(ocupado), 32'd1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    pronto_q.delete();
    #1;
    chk("async_reset_tx", 32'(tx_serial), 32'd1);
    chk("async_reset_ocupado", 32'(ocupado), 32'd0);
    chk("async_reset_estado", 32'(db_estado), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(10);
    request();
    wait_pronto(2000);
    idle(20);

    chk("frames_left", exp_q.size(), 0);
    chk("prontos_left", pronto_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
